// File: rtl/tbird_light_decoder.sv
// Receive-side checker for the T-bird tail-light sequence: tracks the lamp
// pattern, decodes the mode, and flags completed sequences and illegal steps.
module tbird_light_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       l_lights,
  input  logic [2:0]       r_lights,
  output logic [1:0]       mode,
  output logic             seq_done,
  output logic             err,
  output logic [CNT_W-1:0] seq_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned LAMP_W = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_L1, S_L2, S_L3, S_LOFF,
    S_R1, S_R2, S_R3, S_ROFF, S_HON, S_HOFF
  } state_e;

  typedef enum logic [3:0] {
    C_Z, C_L1, C_L2, C_L3, C_R1, C_R2, C_R3, C_H, C_BAD
  } cls_e;

  localparam logic [LAMP_W-1:0] OFF = 3'b000;
  localparam logic [LAMP_W-1:0] ON1 = 3'b001;
  localparam logic [LAMP_W-1:0] ON2 = 3'b011;
  localparam logic [LAMP_W-1:0] ON3 = 3'b111;

  state_e     state_q;
  state_e     state_d;
  state_e     resync_state;
  cls_e       cls;
  logic       resync_legal;
  logic       legal;
  logic       done_d;
  logic       err_d;
  logic [1:0] mode_d;

  // Classify the current lamp sample into one of the legal pattern classes.
  always_comb begin
    cls = C_BAD;
    case ({l_lights, r_lights})
      {OFF, OFF}: cls = C_Z;
      {ON1, OFF}: cls = C_L1;
      {ON2, OFF}: cls = C_L2;
      {ON3, OFF}: cls = C_L3;
      {OFF, ON1}: cls = C_R1;
      {OFF, ON2}: cls = C_R2;
      {OFF, ON3}: cls = C_R3;
      {ON3, ON3}: cls = C_H;
      default:    cls = C_BAD;
    endcase
  end

  // IDLE-row decode, also used to resynchronise after an error.
  always_comb begin
    resync_state = S_IDLE;
    resync_legal = 1'b0;
    case (cls)
      C_Z:     begin resync_state = S_IDLE; resync_legal = 1'b1; end
      C_L1:    begin resync_state = S_L1;   resync_legal = 1'b1; end
      C_R1:    begin resync_state = S_R1;   resync_legal = 1'b1; end
      C_H:     begin resync_state = S_HON;  resync_legal = 1'b1; end
      default: begin resync_state = S_IDLE; resync_legal = 1'b0; end
    endcase
  end

  // Next-state and pulse decode.
  always_comb begin
    state_d = S_IDLE;
    legal   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mode_d  = 2'b00;

    case (state_q)
      S_IDLE, S_LOFF, S_ROFF, S_HOFF: begin
        legal   = resync_legal;
        state_d = resync_state;
      end
      S_L1: if (cls == C_L2) begin legal = 1'b1; state_d = S_L2; end
      S_L2: if (cls == C_L3) begin legal = 1'b1; state_d = S_L3; end
      S_L3: if (cls == C_Z)  begin legal = 1'b1; state_d = S_LOFF; done_d = 1'b1; end
      S_R1: if (cls == C_R2) begin legal = 1'b1; state_d = S_R2; end
      S_R2: if (cls == C_R3) begin legal = 1'b1; state_d = S_R3; end
      S_R3: if (cls == C_Z)  begin legal = 1'b1; state_d = S_ROFF; done_d = 1'b1; end
      S_HON: if (cls == C_Z) begin legal = 1'b1; state_d = S_HOFF; done_d = 1'b1; end
      default: begin
        legal   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Hazard preempts any turn sequence in progress.
    if ((state_q inside {S_L1, S_L2, S_L3, S_R1, S_R2, S_R3}) && (cls == C_H)) begin
      legal   = 1'b1;
      state_d = S_HON;
    end

    if (!legal) begin
      err_d   = 1'b1;
      done_d  = 1'b0;
      state_d = resync_state;
    end

    case (state_d)
      S_L1, S_L2, S_L3, S_LOFF: mode_d = 2'b01;
      S_R1, S_R2, S_R3, S_ROFF: mode_d = 2'b10;
      S_HON, S_HOFF:            mode_d = 2'b11;
      default:                  mode_d = 2'b00;
    endcase
  end

  // State and registered outputs; reset wins over sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode      <= 2'b00;
      seq_done  <= 1'b0;
      err       <= 1'b0;
      seq_count <= '0;
      err_count <= '0;
    end else begin
      state_q  <= state_d;
      mode     <= mode_d;
      seq_done <= done_d;
      err      <= err_d;
      if (done_d) begin
        seq_count <= seq_count + CNT_W'(1);
      end
      if (err_d && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_tbird_light_decoder.sv
// Directed self-checking bench for tbird_light_decoder; a second instance
// with 2-bit counters covers error-count saturation.
module tb_tbird_light_decoder;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] B1  = 3'b001;
  localparam logic [2:0] B2  = 3'b011;
  localparam logic [2:0] B3  = 3'b111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] l_lights = OFF;
  logic [2:0] r_lights = OFF;

  logic [1:0] mode, mode_s;
  logic       seq_done, seq_done_s;
  logic       err, err_s;
  logic [7:0] seq_count, err_count;
  logic [1:0] seq_count_s, err_count_s;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  tbird_light_decoder #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .l_lights(l_lights), .r_lights(r_lights),
    .mode(mode), .seq_done(seq_done), .err(err),
    .seq_count(seq_count), .err_count(err_count)
  );

  tbird_light_decoder #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .l_lights(l_lights), .r_lights(r_lights),
    .mode(mode_s), .seq_done(seq_done_s), .err(err_s),
    .seq_count(seq_count_s), .err_count(err_count_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [2:0] l, input logic [2:0] r);
    l_lights = l;
    r_lights = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input int m, input int d, input int e,
                            input int sc, input int ec);
    check({tag, ".mode"}, 32'(mode), 32'(m));
    check({tag, ".done"}, 32'(seq_done), 32'(d));
    check({tag, ".err"},  32'(err), 32'(e));
    check({tag, ".seq"},  32'(seq_count), 32'(sc));
    check({tag, ".errc"}, 32'(err_count), 32'(ec));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(OFF, OFF);
    rst = 1'b0;
  endtask

  initial begin
    // Reset held with Z for three cycles.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(OFF, OFF);
      expect_all("rst", 0, 0, 0, 0, 0);
    end
    rst = 1'b0;

    // Left cycle.
    step(B1, OFF);  expect_all("l_l1", 1, 0, 0, 0, 0);
    step(B2, OFF);  expect_all("l_l2", 1, 0, 0, 0, 0);
    step(B3, OFF);  expect_all("l_l3", 1, 0, 0, 0, 0);
    step(OFF, OFF); expect_all("l_z",  1, 1, 0, 1, 0);
    step(B1, OFF);  expect_all("l_l1b", 1, 0, 0, 1, 0);

    // Right cycle twice then Z.
    do_reset();
    step(OFF, B1);  expect_all("r_r1", 2, 0, 0, 0, 0);
    step(OFF, B2);  expect_all("r_r2", 2, 0, 0, 0, 0);
    step(OFF, B3);  expect_all("r_r3", 2, 0, 0, 0, 0);
    step(OFF, OFF); expect_all("r_z",  2, 1, 0, 1, 0);
    step(OFF, B1);  expect_all("r_r1b", 2, 0, 0, 1, 0);
    step(OFF, B2);  expect_all("r_r2b", 2, 0, 0, 1, 0);
    step(OFF, B3);  expect_all("r_r3b", 2, 0, 0, 1, 0);
    step(OFF, OFF); expect_all("r_zb", 2, 1, 0, 2, 0);
    step(OFF, OFF); expect_all("r_zz", 0, 0, 0, 2, 0);

    // Hazard preempts a left turn.
    do_reset();
    step(B1, OFF);  expect_all("h_l1", 1, 0, 0, 0, 0);
    step(B2, OFF);  expect_all("h_l2", 1, 0, 0, 0, 0);
    step(B3, B3);   expect_all("h_h",  3, 0, 0, 0, 0);
    step(OFF, OFF); expect_all("h_z",  3, 1, 0, 1, 0);
    step(B3, B3);   expect_all("h_h2", 3, 0, 0, 1, 0);
    step(OFF, OFF); expect_all("h_z2", 3, 1, 0, 2, 0);
    step(OFF, OFF); expect_all("h_zz", 0, 0, 0, 2, 0);

    // Repeated H is an error and resyncs into HON.
    step(B3, B3);   expect_all("hh_1", 3, 0, 0, 2, 0);
    step(B3, B3);   expect_all("hh_2", 3, 0, 1, 2, 1);

    // Illegal patterns and transitions.
    do_reset();
    step(B1, OFF);  expect_all("i_l1",  1, 0, 0, 0, 0);
    step(OFF, B2);  expect_all("i_r2",  0, 0, 1, 0, 1);
    step(3'b101, OFF); expect_all("i_bad", 0, 0, 1, 0, 2);
    step(B1, OFF);  expect_all("i_l1b", 1, 0, 0, 0, 2);
    step(B1, OFF);  expect_all("i_l1r", 1, 0, 1, 0, 3);
    step(B2, OFF);  expect_all("i_l2",  1, 0, 0, 0, 3);

    // L3 right after reset is decoded with the IDLE row.
    do_reset();
    step(B3, OFF);  expect_all("rl3", 0, 0, 1, 0, 1);

    // Saturation on the 2-bit instance; the 8-bit one keeps counting.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      step(3'b101, OFF);
      check("sat.err",   32'(err_s), 32'd1);
      check("sat.errc2", 32'(err_count_s), (i > 3) ? 32'd3 : 32'(i));
      check("sat.errc8", 32'(err_count), 32'(i));
    end

    // Reset mid right-sequence discards progress.
    do_reset();
    step(OFF, B1);  expect_all("mr_r1", 2, 0, 0, 0, 0);
    step(OFF, B2);  expect_all("mr_r2", 2, 0, 0, 0, 0);
    rst = 1'b1;
    step(OFF, B3);  expect_all("mr_rst", 0, 0, 0, 0, 0);
    check("mr_rst.mode_s", 32'(mode_s), 32'd0);
    check("mr_rst.errc_s", 32'(err_count_s), 32'd0);
    rst = 1'b0;
    step(OFF, B1);  expect_all("mr_r1b", 2, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
